// File: rtl/bram_bank_loader.sv
// bram_bank_loader: stripes a valid/ready word stream round-robin across the BRAM bank write ports.
// Define LOADER_STALL_CNT_EN to add o_stall_cnt, a saturating count of LOAD cycles without i_vld.
module bram_bank_loader #(
   parameter int NUM_BANK = 16,
   parameter int DW       = 128,
   parameter int AW       = 9,
   parameter int DEPTH    = 512,
   parameter int CW       = 14
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                iStart,
   input  logic [CW-1:0]       i_num_words,
   input  logic [AW-1:0]       i_base_addr,
   input  logic                i_vld,
   output logic                o_rdy,
   input  logic [DW-1:0]       i_data,
   output logic [NUM_BANK-1:0] o_ena,
   output logic [NUM_BANK-1:0] o_wea,
   output logic [AW-1:0]       o_addra,
   output logic [DW-1:0]       o_dia,
   output logic                o_busy,
   output logic                o_done,
   output logic                o_err
`ifdef LOADER_STALL_CNT_EN
   ,
   output logic [15:0]         o_stall_cnt
`endif
);
   localparam int BW = $clog2(NUM_BANK);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;
   localparam logic [CW-1:0] MAX_WORDS = CW'(NUM_BANK * DEPTH);
   logic [1:0]          state_q, state_d;
   logic [CW-1:0]       num_q, num_d, cnt_q, cnt_d;
   logic [AW-1:0]       base_q, base_d, row_q, row_d, addr_q, addr_d;
   logic [BW-1:0]       bank_q, bank_d;
   logic [NUM_BANK-1:0] ena_q, ena_d;
   logic [DW-1:0]       dia_q, dia_d;
   logic                err_q, err_d;
   logic                start, acc, wrap, last_bank;
   logic [AW:0]         sum;
   always_comb begin
      start     = state_q == S_IDLE && iStart;
      acc       = state_q == S_LOAD && i_vld;
      last_bank = bank_q == BW'(NUM_BANK - 1);
      sum       = {1'b0, base_q} + {1'b0, row_q};
      wrap      = sum >= (AW+1)'(DEPTH);
      num_d     = start ? (i_num_words > MAX_WORDS ? MAX_WORDS : i_num_words) : num_q;
      base_d    = start ? i_base_addr : base_q;
      bank_d    = start ? '0 : acc ? (last_bank ? '0 : bank_q + 1'b1) : bank_q;
      row_d     = start ? '0 : (acc && last_bank) ? row_q + 1'b1 : row_q;
      cnt_d     = start ? '0 : acc ? cnt_q + 1'b1 : cnt_q;
      err_d     = start ? 1'b0 : err_q | (acc & wrap);
      ena_d     = acc ? NUM_BANK'(1) << bank_q : '0;
      addr_d    = acc ? (wrap ? AW'(sum - (AW+1)'(DEPTH)) : sum[AW-1:0]) : addr_q;
      dia_d     = acc ? i_data : dia_q;
      state_d   = start ? (i_num_words == '0 ? S_DONE : S_LOAD)
                : (acc && cnt_q == num_q - 1'b1) ? S_DONE
                : state_q == S_DONE ? S_IDLE : state_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         num_q   <= '0;
         cnt_q   <= '0;
         base_q  <= '0;
         row_q   <= '0;
         bank_q  <= '0;
         addr_q  <= '0;
         ena_q   <= '0;
         dia_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         num_q   <= num_d;
         cnt_q   <= cnt_d;
         base_q  <= base_d;
         row_q   <= row_d;
         bank_q  <= bank_d;
         addr_q  <= addr_d;
         ena_q   <= ena_d;
         dia_q   <= dia_d;
         err_q   <= err_d;
      end
   end
   assign o_rdy   = state_q == S_LOAD;
   assign o_busy  = state_q != S_IDLE;
   assign o_done  = state_q == S_DONE;
   assign o_ena   = ena_q;
   assign o_wea   = ena_q;
   assign o_addra = addr_q;
   assign o_dia   = dia_q;
   assign o_err   = err_q;
`ifdef LOADER_STALL_CNT_EN
   logic [15:0] stall_q, stall_d;
   always_comb
      stall_d = start ? '0 : (state_q == S_LOAD && !i_vld && stall_q != 16'hFFFF) ? stall_q + 1'b1 : stall_q;
   always_ff @(posedge clk)
      stall_q <= rst ? '0 : stall_d;
   assign o_stall_cnt = stall_q;
`endif
endmodule
